instr_fetch: RTL and testbench

Instruction fetch stage feeding the decode controller. It keeps the fetch PC and issues in-order word reads to instruction memory over a request/grant + response-valid interface. Returned words are buffered in a small FIFO and presented to decode as IR with a valid/ready handshake. A single-cycle redirect from the branch/jump resolution logic restarts fetch at a new PC. The redirect flushes the buffer and discards in-flight responses.

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 142 ++++++++++++++
 tb/tb_instr_fetch.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and the decode-side IR handshake.
// The master modport is the fetch unit; the slave modport is the memory/decode/branch side.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, ir_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: in-order word reads from imem, credit-limited IR FIFO to decode,
// single-cycle redirect that flushes the FIFO and drops every in-flight response.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | held since reset, no requests issued
// ST_RUN  | fetching; entered on first edge after reset
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic            run;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   total_out_q, total_out_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     mem_pc_q [DEPTH];
    logic [31:0]     mem_pc_d [DEPTH];
    logic [31:0]     mem_word_q [DEPTH];
    logic [31:0]     mem_word_d [DEPTH];

    logic [CW-1:0]   live;
    logic [CW:0]     credit;
    logic            req;
    logic            issue;
    logic            rsp;
    logic            push;
    logic            pop;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run = (state_q == ST_RUN);
    end

    always_comb begin
        live   = total_out_q - discard_q;
        credit = {1'b0, count_q} + {1'b0, live};
        // Issue only when every live request is guaranteed a FIFO slot on return.
        req    = run & ~bus.redirect & (discard_q == '0) & (credit < DEPTH_C);
        issue  = req & bus.imem_gnt;
        rsp    = bus.imem_rvalid & (total_out_q != '0);
        push   = rsp & (discard_q == '0) & ~bus.redirect;
        pop    = (count_q != '0) & bus.ir_ready & ~bus.redirect;

        total_out_d = total_out_q + CW'(issue) - CW'(rsp);

        discard_d = discard_q;
        if (bus.redirect) begin
            discard_d = total_out_q - CW'(rsp);
        end else if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)  resp_pc_d  = resp_pc_q + 32'd4;
        end

        count_d  = bus.redirect ? '0 : count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = bus.redirect ? wr_ptr_q : (pop ? rd_ptr_q + PW'(1) : rd_ptr_q);

        mem_pc_d   = mem_pc_q;
        mem_word_d = mem_word_q;
        if (push) begin
            mem_pc_d[wr_ptr_q]   = resp_pc_q;
            mem_word_d[wr_ptr_q] = bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            count_q     <= '0;
            total_out_q <= '0;
            discard_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= RESET_PC;
                mem_word_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            count_q     <= count_d;
            total_out_q <= total_out_d;
            discard_q   <= discard_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_pc_q    <= mem_pc_d;
            mem_word_q  <= mem_word_d;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.ir_valid  = (count_q != '0);
    assign bus.ir        = mem_word_q[rd_ptr_q];
    assign bus.ir_pc     = mem_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order imem responder with programmable latency, queue-based
// fetch model compared every cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] addr; } mreq_t;
    typedef struct { int cyc; logic [31:0] addr; } ev_t;

    mreq_t       mq[$];
    ev_t         glog[$];
    ev_t         dlog[$];
    logic [31:0] dword[$];

    int          lat;
    int          cyc;
    int          rel;
    int          proto_rv;
    int          n_checks;
    int          n_err;

    logic        m_run;
    logic [31:0] m_fetch;
    logic [31:0] m_resp;
    logic [63:0] m_fifo[$];
    int          m_out;
    int          m_disc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_grant(input string name, input int idx, input int ecyc, input logic [31:0] eaddr);
        if (idx >= glog.size()) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: grant %0d missing, got %0d grants expected more", name, idx, glog.size());
        end else begin
            chk({name, "_cyc"}, glog[idx].cyc, ecyc);
            chk({name, "_addr"}, glog[idx].addr, eaddr);
        end
    endtask

    task automatic chk_dlv(input string name, input int idx, input int ecyc, input logic [31:0] epc);
        if (idx >= dlog.size()) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: delivery %0d missing, got %0d deliveries expected more", name, idx, dlog.size());
        end else begin
            if (ecyc >= 0) chk({name, "_cyc"}, dlog[idx].cyc, ecyc);
            chk({name, "_pc"}, dlog[idx].addr, epc);
        end
    endtask

    // One clock cycle: compare + model update at mid-cycle, then responder drive after the edge.
    task automatic tick();
        bit exp_req;
        bit issue;
        bit rv;
        #1;
        if (!rst_n) begin
            chk("rst_req", bus.imem_req, 32'd0);
            chk("rst_ir_valid", bus.ir_valid, 32'd0);
            m_run   = 1'b0;
            m_fetch = RESET_PC;
            m_resp  = RESET_PC;
            m_fifo.delete();
            m_out   = 0;
            m_disc  = 0;
        end else begin
            exp_req = m_run && !bus.redirect && (m_disc == 0) &&
                      (m_fifo.size() + m_out - m_disc < DEPTH);
            chk("req", bus.imem_req, exp_req);
            if (exp_req) chk("addr", bus.imem_addr, m_fetch);
            chk("ir_valid", bus.ir_valid, m_fifo.size() != 0);
            if (m_fifo.size() != 0) begin
                chk("ir_pc", bus.ir_pc, m_fifo[0][63:32]);
                chk("ir", bus.ir, m_fifo[0][31:0]);
            end
            issue = exp_req && bus.imem_gnt;
            rv    = bus.imem_rvalid && (m_out != 0);
            if (bus.imem_rvalid && m_out == 0) proto_rv++;
            if (issue) glog.push_back('{cyc: cyc, addr: m_fetch});
            if (bus.redirect) begin
                m_fifo.delete();
                m_fetch = bus.redirect_pc;
                m_resp  = bus.redirect_pc;
                m_disc  = m_out - int'(rv);
                m_out   = m_out - int'(rv);
            end else begin
                if (m_fifo.size() != 0 && bus.ir_ready) begin
                    dlog.push_back('{cyc: cyc, addr: m_fifo[0][63:32]});
                    dword.push_back(m_fifo[0][31:0]);
                    void'(m_fifo.pop_front());
                end
                if (issue) begin
                    m_fetch = m_fetch + 32'd4;
                    m_out++;
                end
                if (rv) begin
                    m_out--;
                    if (m_disc > 0) m_disc--;
                    else begin
                        m_fifo.push_back({m_resp, bus.imem_rdata});
                        m_resp = m_resp + 32'd4;
                    end
                end
            end
            m_run = 1'b1;
        end
        if (bus.imem_rvalid && mq.size() != 0) void'(mq.pop_front());
        if (bus.imem_req && bus.imem_gnt) mq.push_back('{due: cyc + lat, addr: bus.imem_addr});
        @(posedge clk);
        cyc++;
        #1;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mq[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'd0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input bit keep, input int n);
        rst_n = 1'b0;
        if (!keep) begin
            mq.delete();
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'd0;
        end
        #1;
        chk("rst_imem_req", bus.imem_req, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_ir_valid_now", bus.ir_valid, 32'd0);
        chk("rst_ir", bus.ir, 32'd0);
        chk("rst_ir_pc", bus.ir_pc, RESET_PC);
        run(n);
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        glog.delete();
        dlog.delete();
        dword.delete();
        rel = cyc;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        proto_rv = 0;
        lat      = 1;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.ir_ready    = 1'b1;
        @(negedge clk);

        // Streaming, L = 1
        lat = 1; bus.ir_ready = 1'b1;
        do_reset(1'b0, 2);
        release_rst();
        run(14);
        chk_grant("t1_g0", 0, rel + 1, 32'h0);
        chk_grant("t1_g1", 1, rel + 2, 32'h4);
        for (int i = 0; i < 8; i++) chk_dlv("t1_dlv", i, rel + 3 + i, 32'(4 * i));
        if (dword.size() >= 3) begin
            chk("t1_word0", dword[0], 32'hA5A5_5A5A);
            chk("t1_word2", dword[2], 32'hA5A5_5A52);
        end else begin
            chk("t1_words_present", dword.size(), 32'd3);
        end

        // Decode stalled
        do_reset(1'b0, 2);
        bus.ir_ready = 1'b0;
        release_rst();
        run(12);
        chk("t2_ngrant", glog.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk_grant("t2_g", i, rel + 1 + i, 32'(4 * i));
        chk("t2_req_off", bus.imem_req, 32'd0);
        chk("t2_hold_valid", bus.ir_valid, 32'd1);
        chk("t2_hold_pc", bus.ir_pc, 32'h0);
        chk("t2_hold_ir", bus.ir, 32'hA5A5_5A5A);
        chk("t2_ndlv", dlog.size(), 32'd0);
        bus.ir_ready = 1'b1;
        run(8);
        for (int i = 0; i < 4; i++) chk_dlv("t2_drain", i, rel + 12 + i, 32'(4 * i));
        chk_grant("t2_resume", 4, rel + 13, 32'h10);
        chk_dlv("t2_next", 4, -1, 32'h10);

        // Redirect with three requests in flight, L = 3
        do_reset(1'b0, 2);
        lat = 3; bus.ir_ready = 1'b1;
        release_rst();
        run(4);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
        run(1);
        bus.redirect = 1'b0;
        run(14);
        chk_grant("t3_g0", 0, rel + 1, 32'h0);
        chk_grant("t3_g2", 2, rel + 3, 32'h8);
        chk_grant("t3_new", 3, rel + 7, 32'h100);
        chk_grant("t3_new1", 4, rel + 8, 32'h104);
        chk_dlv("t3_d0", 0, rel + 11, 32'h100);
        chk_dlv("t3_d1", 1, rel + 12, 32'h104);

        // Redirect colliding with rvalid and ir_ready, FIFO non-empty, L = 2
        do_reset(1'b0, 2);
        lat = 2; bus.ir_ready = 1'b0;
        release_rst();
        run(5);
        chk("t4_fifo_nonempty", bus.ir_valid, 32'd1);
        chk("t4_rvalid_now", bus.imem_rvalid, 32'd1);
        bus.ir_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        run(1);
        bus.redirect = 1'b0;
        #1;
        chk("t4_valid_cleared", bus.ir_valid, 32'd0);
        chk("t4_req_blocked", bus.imem_req, 32'd0);
        run(10);
        chk_grant("t4_g3", 3, rel + 4, 32'hC);
        chk_grant("t4_new", 4, rel + 7, 32'h200);
        chk_dlv("t4_d0", 0, rel + 10, 32'h200);

        // Address wrap
        do_reset(1'b0, 2);
        lat = 1; bus.ir_ready = 1'b1;
        release_rst();
        run(1);
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
        run(1);
        bus.redirect = 1'b0;
        run(10);
        chk_grant("t5_g0", 0, rel + 2, 32'hFFFF_FFF8);
        chk_grant("t5_g1", 1, rel + 3, 32'hFFFF_FFFC);
        chk_grant("t5_g2", 2, rel + 4, 32'h0);
        chk_grant("t5_g3", 3, rel + 5, 32'h4);
        chk_dlv("t5_d0", 0, rel + 4, 32'hFFFF_FFF8);
        chk_dlv("t5_d1", 1, rel + 5, 32'hFFFF_FFFC);
        chk_dlv("t5_d2", 2, rel + 6, 32'h0);
        chk_dlv("t5_d3", 3, rel + 7, 32'h4);
        if (dword.size() != 0) chk("t5_word0", dword[0], 32'h5A5A_A5A2);
        else chk("t5_word_present", dword.size(), 32'd1);

        // Reset mid-stream with two requests outstanding, L = 3
        chk("t6_no_proto_before", proto_rv, 32'd0);
        do_reset(1'b0, 2);
        lat = 3; bus.ir_ready = 1'b1;
        release_rst();
        run(3);
        chk("t6_outstanding", glog.size(), 32'd2);
        do_reset(1'b1, 1);
        release_rst();
        run(10);
        chk("t6_late_rvalids", proto_rv, 32'd2);
        chk_grant("t6_g0", 0, rel + 1, RESET_PC);
        chk_grant("t6_g1", 1, rel + 2, RESET_PC + 32'h4);
        chk_dlv("t6_d0", 0, rel + 5, RESET_PC);
        chk_dlv("t6_d1", 1, rel + 6, RESET_PC + 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
